// File: rtl/fb_scanout_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter, vga_sync, the compute engine and the BRAM.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface fb_scanout_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
);
    // vga_sync side
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              video_on;
    logic              p_tick;
    logic              display;
    // clear control
    logic              clear_req;
    logic              busy_clear;
    logic              frame_start;
    // engine write port
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;
    // BRAM port
    logic              fb_en;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_wdata;
    logic [PIX_W-1:0]  fb_rdata;
    // DAC colour
    logic [PIX_W-1:0]  pix_color;

    modport master (
        input  pixel_x, pixel_y, video_on, p_tick, clear_req,
        input  wr_valid, wr_addr, wr_data, fb_rdata,
        output display, busy_clear, frame_start, wr_ready,
        output fb_en, fb_we, fb_addr, fb_wdata, pix_color
    );

    modport slave (
        output pixel_x, pixel_y, video_on, p_tick, clear_req,
        output wr_valid, wr_addr, wr_data, fb_rdata,
        input  display, busy_clear, frame_start, wr_ready,
        input  fb_en, fb_we, fb_addr, fb_wdata, pix_color
    );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// Frame-buffer owner: shares one single-port BRAM between VGA scanout reads and
// engine writes, and clears the buffer after reset or on request.
// The scanout read takes the cycle after each falling edge of p_tick; the engine
// may write in any other RUN cycle, so wr_ready is a direct decode of that slot.
module fb_scanout_arbiter #(
    parameter int              FB_W        = 320,
    parameter int              FB_H        = 240,
    parameter int              SCALE_SHIFT = 1,
    parameter int              PIX_W       = 8,
    parameter int              ADDR_W      = 17,
    parameter int              RD_LAT      = 1,
    parameter logic [PIX_W-1:0] CLEAR_VAL  = '0
) (
    input  logic                 CLK_100MHz,
    input  logic                 reset_n,
    fb_scanout_arbiter_if.master bus
);
    localparam int                FB_SIZE   = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(FB_SIZE);
    localparam logic [9:0]        VBLANK_Y  = 10'(FB_H << SCALE_SHIFT);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            next_state;
    logic              p_tick_d;
    logic              det;
    logic              wr_ready_c;
    logic              accept;
    logic              take_clear;
    logic              clr_latch;
    logic              wr_in_range;
    logic              wr_inflight;
    logic              vblank_line;
    logic [ADDR_W-1:0] clr_ptr;
    logic              vld_p0, vld_p1, vld_p2;
    logic              vis_p0, vis_p1, vis_p2;
    logic              ld_vld;
    logic              ld_vis;

    // Screen coordinate to linear frame-buffer address; the 32-bit intermediate
    // keeps the product exact before narrowing to the address width.
    function automatic logic [ADDR_W-1:0] scan_addr(input logic [9:0] x, input logic [9:0] y);
        logic [31:0] lin;
        lin = 32'(y >> SCALE_SHIFT) * 32'(FB_W) + 32'(x >> SCALE_SHIFT);
        return lin[ADDR_W-1:0];
    endfunction

    assign det          = p_tick_d & ~bus.p_tick;
    assign wr_in_range  = {1'b0, bus.wr_addr} < FB_LIMIT;
    assign wr_inflight  = bus.fb_en & bus.fb_we;
    assign vblank_line  = (bus.pixel_y == VBLANK_Y);
    assign accept       = bus.wr_valid & wr_ready_c;
    assign bus.wr_ready = wr_ready_c;
    assign ld_vld       = (RD_LAT == 2) ? vld_p2 : vld_p1;
    assign ld_vis       = (RD_LAT == 2) ? vis_p2 : vis_p1;

    // State register
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) state <= CLEAR;
        else          state <= next_state;
    end

    // Next state, write-slot grant and the decision to start a requested clear
    always_comb begin
        next_state = state;
        wr_ready_c = 1'b0;
        take_clear = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_ptr == LAST_ADDR) next_state = RUN;
            end
            RUN: begin
                wr_ready_c = ~det;
                if (det && clr_latch && vblank_line && !wr_inflight) begin
                    take_clear = 1'b1;
                    next_state = CLEAR;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    // Pixel-tick history, clear pointer and sticky clear-request latch
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            p_tick_d  <= 1'b0;
            clr_ptr   <= '0;
            clr_latch <= 1'b0;
        end else begin
            p_tick_d <= bus.p_tick;
            if (state == CLEAR) clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + ADDR_W'(1);
            if (state == CLEAR || take_clear) clr_latch <= 1'b0;
            else if (bus.clear_req)           clr_latch <= 1'b1;
        end
    end

    // Registered BRAM port: clear writes, then engine writes, then scanout reads
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            bus.fb_en    <= 1'b0;
            bus.fb_we    <= 1'b0;
            bus.fb_addr  <= '0;
            bus.fb_wdata <= '0;
        end else begin
            bus.fb_en <= 1'b0;
            bus.fb_we <= 1'b0;
            if (state == CLEAR) begin
                bus.fb_en    <= 1'b1;
                bus.fb_we    <= 1'b1;
                bus.fb_addr  <= clr_ptr;
                bus.fb_wdata <= CLEAR_VAL;
            end else if (accept) begin
                // Out-of-range writes complete the handshake but never reach the BRAM
                if (wr_in_range) begin
                    bus.fb_en    <= 1'b1;
                    bus.fb_we    <= 1'b1;
                    bus.fb_addr  <= bus.wr_addr;
                    bus.fb_wdata <= bus.wr_data;
                end
            end else if (det && bus.video_on) begin
                bus.fb_en   <= 1'b1;
                bus.fb_addr <= scan_addr(bus.pixel_x, bus.pixel_y);
            end
        end
    end

    // Scanout pipeline: p0 = read on the bus, p1/p2 = BRAM data returning
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            vis_p0        <= 1'b0;
            vis_p1        <= 1'b0;
            vis_p2        <= 1'b0;
            bus.pix_color <= '0;
        end else begin
            vld_p0 <= (state == RUN) & det;
            vis_p0 <= bus.video_on;
            vld_p1 <= vld_p0;
            vis_p1 <= vis_p0;
            vld_p2 <= vld_p1;
            vis_p2 <= vis_p1;
            if (ld_vld) bus.pix_color <= ld_vis ? bus.fb_rdata : '0;
        end
    end

    // Status outputs track the state being entered so display drops as CLEAR begins
    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            bus.display     <= 1'b0;
            bus.busy_clear  <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.display     <= (next_state == RUN);
            bus.busy_clear  <= (next_state == CLEAR);
            bus.frame_start <= (state == RUN) && det &&
                               (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
        end
    end
endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter. The frame buffer is shortened to 320x24
// so full clears stay short; the read-address example (101,47) -> 7410 still holds,
// the first vblank line becomes 48 and the first out-of-range address 7680.
module tb_fb_scanout_arbiter;
    localparam int FB_W    = 320;
    localparam int FB_H    = 24;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int ADDR_W  = 17;
    localparam int PIX_W   = 8;
    localparam int ABORT_PTR = 4000;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    int   wr_count;
    int   en_count;
    logic [PIX_W-1:0] mem [0:FB_SIZE-1];
    logic [PIX_W-1:0] rdata_q;

    fb_scanout_arbiter_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    fb_scanout_arbiter #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(1), .PIX_W(PIX_W),
        .ADDR_W(ADDR_W), .RD_LAT(1), .CLEAR_VAL(8'h00)
    ) dut (
        .CLK_100MHz(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model with one cycle of read latency, plus access counters
    always @(posedge clk) begin
        if (bus.fb_en === 1'b1) begin
            en_count <= en_count + 1;
            if (bus.fb_we === 1'b1) begin
                wr_count <= wr_count + 1;
                if (int'(bus.fb_addr) < FB_SIZE) mem[bus.fb_addr[12:0]] <= bus.fb_wdata;
            end else begin
                rdata_q <= (int'(bus.fb_addr) < FB_SIZE) ? mem[bus.fb_addr[12:0]] : 8'h00;
            end
        end
    end
    assign bus.fb_rdata = rdata_q;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Two p_tick-high cycles, then the det cycle with the given coordinates applied
    task automatic pre_det(input logic [9:0] x, input logic [9:0] y, input logic von);
        @(negedge clk); bus.p_tick = 1'b1;
        @(negedge clk); bus.p_tick = 1'b1;
        @(negedge clk); bus.p_tick = 1'b0; bus.pixel_x = x; bus.pixel_y = y; bus.video_on = von;
    endtask

    // Steps through one full clear and counts cycles that differ from the expected write
    task automatic run_clear(output int bad);
        bad = 0;
        for (int i = 0; i < FB_SIZE; i++) begin
            @(posedge clk); #1;
            if (bus.fb_en !== 1'b1 || bus.fb_we !== 1'b1 ||
                bus.fb_addr !== 17'(i) || bus.fb_wdata !== 8'h00) bad++;
            if (i < FB_SIZE - 1 && (bus.busy_clear !== 1'b1 || bus.display !== 1'b0 ||
                                    bus.wr_ready !== 1'b0)) bad++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.display !== 1'b0) $display("FAIL reset_display: got %b want 0", bus.display); else n_pass++;
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); else n_pass++;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL reset_fb_en: got %b want 0", bus.fb_en); else n_pass++;
        n_checks++; if (bus.fb_we !== 1'b0) $display("FAIL reset_fb_we: got %b want 0", bus.fb_we); else n_pass++;
        n_checks++; if (bus.fb_addr !== 17'd0) $display("FAIL reset_fb_addr: got %0d want 0", bus.fb_addr); else n_pass++;
        n_checks++; if (bus.fb_wdata !== 8'h00) $display("FAIL reset_fb_wdata: got %h want 00", bus.fb_wdata); else n_pass++;
        n_checks++; if (bus.pix_color !== 8'h00) $display("FAIL reset_pix_color: got %h want 00", bus.pix_color); else n_pass++;
        n_checks++; if (bus.frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", bus.frame_start); else n_pass++;
        n_checks++; if (bus.busy_clear !== 1'b1) $display("FAIL reset_busy_clear: got %b want 1", bus.busy_clear); else n_pass++;
    endtask

    task automatic test_initial_clear;
        int bad;
        @(negedge clk); reset_n = 1'b1;
        run_clear(bad);
        n_checks++; if (bad !== 0) $display("FAIL init_clear_seq: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (bus.display !== 1'b1) $display("FAIL init_clear_display: got %b want 1", bus.display); else n_pass++;
        n_checks++; if (bus.busy_clear !== 1'b0) $display("FAIL init_clear_busy: got %b want 0", bus.busy_clear); else n_pass++;
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL init_clear_wr_ready: got %b want 1", bus.wr_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL init_clear_idle: got fb_en %b want 0", bus.fb_en); else n_pass++;
    endtask

    task automatic test_write_across_det;
        int wc0;
        pre_det(10'd0, 10'd100, 1'b0);
        bus.wr_valid = 1'b1; bus.wr_addr = 17'd5; bus.wr_data = 8'hAA;
        wc0 = wr_count;
        #1;
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL wr_det_ready: got %b want 0", bus.wr_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL wr_det_no_access: got fb_en %b want 0", bus.fb_en); else n_pass++;
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL wr_after_det_ready: got %b want 1", bus.wr_ready); else n_pass++;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        n_checks++;
        if (bus.fb_en !== 1'b1 || bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd5 || bus.fb_wdata !== 8'hAA)
            $display("FAIL wr_land: got en=%b we=%b addr=%0d data=%h want 1 1 5 aa",
                     bus.fb_en, bus.fb_we, bus.fb_addr, bus.fb_wdata);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL wr_single_pulse: got fb_en %b want 0", bus.fb_en); else n_pass++;
        n_checks++; if (wr_count - wc0 !== 1) $display("FAIL wr_count_one: got %0d writes want 1", wr_count - wc0); else n_pass++;
        n_checks++; if (mem[5] !== 8'hAA) $display("FAIL wr_mem5: got %h want aa", mem[5]); else n_pass++;
    endtask

    task automatic test_out_of_range;
        int ec0;
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 17'(FB_SIZE); bus.wr_data = 8'h33;
        ec0 = en_count;
        #1;
        n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL oor_ready: got %b want 1", bus.wr_ready); else n_pass++;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL oor_fb_en: got %b want 0", bus.fb_en); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (en_count - ec0 !== 0) $display("FAIL oor_access_count: got %0d want 0", en_count - ec0); else n_pass++;
    endtask

    task automatic test_scan_read;
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 17'd7410; bus.wr_data = 8'h5C;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        @(posedge clk); #1;
        pre_det(10'd101, 10'd47, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if (bus.fb_en !== 1'b1 || bus.fb_we !== 1'b0 || bus.fb_addr !== 17'd7410)
            $display("FAIL rd_issue: got en=%b we=%b addr=%0d want 1 0 7410", bus.fb_en, bus.fb_we, bus.fb_addr);
        else n_pass++;
        n_checks++; if (bus.pix_color !== 8'h00) $display("FAIL rd_n1_hold: got %h want 00", bus.pix_color); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.pix_color !== 8'h00) $display("FAIL rd_n2_hold: got %h want 00", bus.pix_color); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.pix_color !== 8'h5C) $display("FAIL rd_n3_color: got %h want 5c", bus.pix_color); else n_pass++;
        // blanked slot: no access, colour forced to zero at the same point
        pre_det(10'd20, 10'd300, 1'b0);
        @(posedge clk); #1;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL blank_no_read: got fb_en %b want 0", bus.fb_en); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.pix_color !== 8'h5C) $display("FAIL blank_hold: got %h want 5c", bus.pix_color); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.pix_color !== 8'h00) $display("FAIL blank_color: got %h want 00", bus.pix_color); else n_pass++;
    endtask

    task automatic test_frame_start;
        pre_det(10'd0, 10'd0, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (bus.frame_start !== 1'b1) $display("FAIL fs_pulse: got %b want 1", bus.frame_start); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.frame_start !== 1'b0) $display("FAIL fs_one_cycle: got %b want 0", bus.frame_start); else n_pass++;
        pre_det(10'd0, 10'd1, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (bus.frame_start !== 1'b0) $display("FAIL fs_other_line: got %b want 0", bus.frame_start); else n_pass++;
    endtask

    task automatic test_clear_request;
        int wc0;
        int bad;
        pre_det(10'd0, 10'd100, 1'b0);
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        n_checks++; if (bus.display !== 1'b1) $display("FAIL creq_wait_display: got %b want 1", bus.display); else n_pass++;
        n_checks++; if (bus.busy_clear !== 1'b0) $display("FAIL creq_wait_busy: got %b want 0", bus.busy_clear); else n_pass++;
        pre_det(10'd0, 10'd48, 1'b0);
        bus.wr_valid = 1'b1; bus.wr_addr = 17'd9; bus.wr_data = 8'h77;
        @(posedge clk); #1;
        wc0 = wr_count;
        n_checks++; if (bus.display !== 1'b0) $display("FAIL creq_display_off: got %b want 0", bus.display); else n_pass++;
        n_checks++; if (bus.busy_clear !== 1'b1) $display("FAIL creq_busy_on: got %b want 1", bus.busy_clear); else n_pass++;
        run_clear(bad);
        n_checks++; if (bad !== 0) $display("FAIL creq_clear_seq: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (bus.display !== 1'b1) $display("FAIL creq_display_back: got %b want 1", bus.display); else n_pass++;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        n_checks++;
        if (bus.fb_en !== 1'b1 || bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd9 || bus.fb_wdata !== 8'h77)
            $display("FAIL creq_stalled_write: got en=%b we=%b addr=%0d data=%h want 1 1 9 77",
                     bus.fb_en, bus.fb_we, bus.fb_addr, bus.fb_wdata);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (wr_count - wc0 !== FB_SIZE + 1) $display("FAIL creq_write_total: got %0d want %0d", wr_count - wc0, FB_SIZE + 1); else n_pass++;
        n_checks++; if (mem[9] !== 8'h77) $display("FAIL creq_mem9: got %h want 77", mem[9]); else n_pass++;
        n_checks++; if (mem[7410] !== 8'h00) $display("FAIL creq_mem7410_cleared: got %h want 00", mem[7410]); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int bad;
        @(negedge clk); bus.clear_req = 1'b1;
        @(negedge clk); bus.clear_req = 1'b0;
        pre_det(10'd0, 10'd48, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i <= ABORT_PTR; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.fb_en !== 1'b1 || bus.fb_addr !== 17'(ABORT_PTR))
            $display("FAIL abort_reach_ptr: got en=%b addr=%0d want 1 %0d", bus.fb_en, bus.fb_addr, ABORT_PTR);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.fb_en !== 1'b0) $display("FAIL abort_fb_en: got %b want 0", bus.fb_en); else n_pass++;
        n_checks++; if (bus.busy_clear !== 1'b1) $display("FAIL abort_busy: got %b want 1", bus.busy_clear); else n_pass++;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        run_clear(bad);
        n_checks++; if (bad !== 0) $display("FAIL abort_restart_seq: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (bus.display !== 1'b1) $display("FAIL abort_display: got %b want 1", bus.display); else n_pass++;
        // no request pending after reset, so the vblank line must not start a clear
        pre_det(10'd0, 10'd48, 1'b0);
        @(posedge clk); #1;
        n_checks++; if (bus.display !== 1'b1) $display("FAIL abort_latch_empty: got display %b want 1", bus.display); else n_pass++;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        wr_count      = 0;
        en_count      = 0;
        rdata_q       = 8'h00;
        reset_n       = 1'b0;
        bus.pixel_x   = 10'd0;
        bus.pixel_y   = 10'd0;
        bus.video_on  = 1'b0;
        bus.p_tick    = 1'b0;
        bus.clear_req = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        test_reset();
        test_initial_clear();
        test_write_across_det();
        test_out_of_range();
        test_scan_read();
        test_frame_start();
        test_clear_request();
        test_reset_abort();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
